// File: rtl/uart_rx_receiver.sv
// ============================================================================
// uart_rx_receiver : 8N1 UART receive path, optional even parity
//                    (define UART_RX_PARITY_EN to build the parity bit)
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_rx_receiver #(
  parameter int CLKS_PER_BIT = 439,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] received_data,
  output logic                  frame_err,
  output logic                  parity_err
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'(HALF_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic                  rx_meta_q;
  logic                  rx_s_q;
  state_t                state_q,  state_d;
  logic [CNT_W-1:0]      baud_q,   baud_d;
  logic [BIT_W-1:0]      bit_q,    bit_d;
  logic [DATA_WIDTH-1:0] shift_q,  shift_d;
  logic [DATA_WIDTH-1:0] data_q,   data_d;
  logic                  done_q,   done_d;
  logic                  ferr_q,   ferr_d;
  logic                  baud_tick;

`ifdef UART_RX_PARITY_EN
  logic                  par_q,    par_d;
  logic                  perr_q,   perr_d;
`endif

  assign baud_tick = (baud_q == BAUD_MAX);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          baud_d  = '0;
          bit_d   = '0;
          shift_d = '0;
        end
      end
      S_START: begin
        // A line that is high again at the start-bit centre was only a glitch.
        if (baud_q == HALF_MAX) begin
          baud_d  = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          baud_d  = '0;
          shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (baud_tick) begin
          baud_d  = '0;
          par_d   = rx_s_q;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_tick) begin
          baud_d  = '0;
          state_d = S_IDLE;
          if (rx_s_q) begin
            data_d = shift_q;
            done_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d = (^shift_q) ^ par_q;
`endif
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign done          = done_q;
  assign received_data = data_q;
  assign frame_err     = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err    = perr_q;
`else
  assign parity_err    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_receiver.sv
// Directed self-checking bench for uart_rx_receiver (either parity build).
`default_nettype none

module tb_uart_rx_receiver;

  localparam int C = 439;
  localparam int H = 219;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY = 1'b1;
  localparam int NBITS  = 10;
`else
  localparam bit PARITY = 1'b0;
  localparam int NBITS  = 9;
`endif
  // Pin edge to first visible done cycle: 3 sync/IDLE cycles, half bit, stop centre.
  localparam int LAT = 3 + H + NBITS * C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       done;
  logic [7:0] received_data;
  logic       frame_err;
  logic       parity_err;

  uart_rx_receiver #(
    .CLKS_PER_BIT(C),
    .HALF_BIT    (H),
    .DATA_WIDTH  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .done         (done),
    .received_data(received_data),
    .frame_err    (frame_err),
    .parity_err   (parity_err)
  );

  always #1 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         done_cyc = 0;
  logic [7:0] last_data = 8'h00;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt  = done_cnt + 1;
      last_data = received_data;
      done_cyc  = cyc;
    end
    if (frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
    if (parity_err === 1'b1) perr_cnt = perr_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (C) @(negedge clk);
  endtask

  // Called on a negedge; returns the cycle count at the start edge.
  task automatic send_frame(input logic [7:0] d, input logic par_flip,
                            input logic stop, output int sc);
    logic [10:0] bits;
    bits = {stop, (^d) ^ par_flip, d, 1'b0};
    sc   = cyc;
    for (int i = 0; i < 11; i++) begin
      if (i == 9 && !PARITY) continue;
      send_bit(bits[i]);
    end
    rx = 1'b1;
  endtask

  int sc;
  int b_done, b_ferr, b_perr;

  task automatic snap();
    b_done = done_cnt;
    b_ferr = ferr_cnt;
    b_perr = perr_cnt;
  endtask

  initial begin
    // Reset state
    repeat (5) @(negedge clk);
    check("rst_done", done, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    check("rst_data", received_data, 8'h00);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Good frame 0x95 with correct parity
    snap();
    send_frame(8'h95, 1'b0, 1'b1, sc);
    repeat (20) @(negedge clk);
    check("f95_done_cnt", done_cnt - b_done, 1);
    check("f95_data", last_data, 8'h95);
    check("f95_hold", received_data, 8'h95);
    check("f95_ferr", ferr_cnt - b_ferr, 0);
    check("f95_perr", perr_cnt - b_perr, 0);
    check("f95_latency", done_cyc - sc, LAT);

`ifdef UART_RX_PARITY_EN
    // Same frame, wrong parity bit
    snap();
    send_frame(8'h95, 1'b1, 1'b1, sc);
    repeat (20) @(negedge clk);
    check("p95_done_cnt", done_cnt - b_done, 1);
    check("p95_data", last_data, 8'h95);
    check("p95_perr", perr_cnt - b_perr, 1);
`endif

    // Stop bit low: frame error, data held
    snap();
    send_frame(8'h3C, 1'b0, 1'b0, sc);
    repeat (2 * C) @(negedge clk);
    check("f3c_ferr", ferr_cnt - b_ferr, 1);
    check("f3c_done_cnt", done_cnt - b_done, 0);
    check("f3c_hold", received_data, 8'h95);
    check("f3c_perr", perr_cnt - b_perr, 0);

    // Short low glitch rejected, then 0xA5
    snap();
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (C) @(negedge clk);
    check("glitch_done", done_cnt - b_done, 0);
    check("glitch_ferr", ferr_cnt - b_ferr, 0);
    send_frame(8'hA5, 1'b0, 1'b1, sc);
    repeat (20) @(negedge clk);
    check("fa5_done_cnt", done_cnt - b_done, 1);
    check("fa5_data", last_data, 8'hA5);
    check("fa5_latency", done_cyc - sc, LAT);

    // Back-to-back 0x00 then 0xFF, no idle gap
    snap();
    send_frame(8'h00, 1'b0, 1'b1, sc);
    check("b2b0_done_cnt", done_cnt - b_done, 1);
    check("b2b0_data", last_data, 8'h00);
    send_frame(8'hFF, 1'b0, 1'b1, sc);
    repeat (20) @(negedge clk);
    check("b2b1_done_cnt", done_cnt - b_done, 2);
    check("b2b1_data", last_data, 8'hFF);
    check("b2b1_latency", done_cyc - sc, LAT);
    check("b2b_ferr", ferr_cnt - b_ferr, 0);

    // Reset during data bit 4 aborts the frame
    snap();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    rx = 1'b1;
    repeat (C / 2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_rst_data", received_data, 8'h00);
    check("abort_rst_done", done, 1'b0);
    rst = 1'b0;
    repeat (2 * C) @(negedge clk);
    check("abort_done_cnt", done_cnt - b_done, 0);
    check("abort_ferr", ferr_cnt - b_ferr, 0);
    send_frame(8'h5A, 1'b0, 1'b1, sc);
    repeat (20) @(negedge clk);
    check("f5a_done_cnt", done_cnt - b_done, 1);
    check("f5a_data", last_data, 8'h5A);
    check("f5a_hold", received_data, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_receiver.md
# uart_rx_receiver

Asynchronous serial receiver: an 8N1 UART receive path with optional even parity. It oversamples `rx` with the system clock, detects and qualifies the start bit, samples each bit at its centre, and shifts bits LSB-first into a serial-in/parallel-out register. On a valid stop bit it presents the byte on `received_data` with a one-cycle `done` strobe. It sits between the board RX pin and the command/packet logic.

## Interface
- `CLKS_PER_BIT`, default 439: clock cycles per bit period (878 time units per bit at a 2-unit clock).
- `HALF_BIT`, default `CLKS_PER_BIT/2` (219): cycles from start-edge detection to the start-bit centre check.
- `DATA_WIDTH`, default 8: data bits per frame.
- `clk` input, 1 bit: single system clock; all logic on the rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `rx` input, 1 bit: serial line; idles high; asynchronous to `clk`.
- `done` output, 1 bit: one-cycle pulse when a frame ends with a valid stop bit.
- `received_data` output, `DATA_WIDTH` bits: last valid byte; held until the next valid frame.
- `frame_err` output, 1 bit: one-cycle pulse when the stop bit samples 0.
- `parity_err` output, 1 bit: one-cycle pulse together with `done` on even-parity mismatch; constant 0 without parity.

## Operation
- `rx` passes through a 2-flop synchronizer; all logic uses the synchronized `rx_s`.
- The state machine has states IDLE, START, DATA, PARITY (parity builds only), STOP.
- IDLE:
  - `rx_s`=0 → START; clear the bit counter, baud counter and shift register.
- START:
  - Count `HALF_BIT` cycles, then sample `rx_s`.
  - Sample 0 → DATA, baud counter cleared.
  - Sample 1 → IDLE (glitch rejected; no outputs).
- DATA:
  - Every `CLKS_PER_BIT` cycles (baud counter overflow), sample `rx_s`.
  - Shift the sample in at the MSB and shift right, so the first data bit ends in bit 0 (LSB-first).
  - Increment the bit counter; after `DATA_WIDTH` samples → PARITY if built, else STOP.
- PARITY: after one baud overflow, sample the parity bit and go to STOP.
- STOP: after one baud overflow, sample `rx_s`.
  - Sample 1: load `received_data` from the shift register, pulse `done`; `parity_err` = (XOR of data bits) XOR parity bit, pulsed with `done`.
  - Sample 0: pulse `frame_err`; `received_data` and `done` unchanged.
  - Either case → IDLE.
- In IDLE a new falling edge is accepted in the cycle right after the STOP sample, so back-to-back frames are supported.
- Counters are unsigned, wide enough for `CLKS_PER_BIT-1`, and reset to 0 on overflow.

## Timing
- Let t0 be the first cycle `rx_s`=0 in IDLE (2–3 cycles after the pin edge).
- Start centre check: t0+`HALF_BIT`.
- Data bit k (0-based) sampled at t0+`HALF_BIT`+(k+1)·`CLKS_PER_BIT`.
- Stop sample:
  - Without parity: t0+`HALF_BIT`+9·`CLKS_PER_BIT`.
  - With parity: t0+`HALF_BIT`+10·`CLKS_PER_BIT`.
- `done`, `received_data` update, `parity_err` and `frame_err` are registered and assert in the cycle after the stop sample, for exactly 1 cycle.
- Reset values:
  - `done`, `frame_err`, `parity_err` = 0; `received_data` = 0.
  - State = IDLE; counters and shift register = 0; synchronizer flops = 1.
- Reset asserted mid-frame aborts the frame immediately; no `done` is produced for it.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is built; the frame is start + 8 data + even-parity bit + stop.
  - `parity_err` is live.
- Not defined:
  - Frame is start + 8 data + stop.
  - `parity_err` is tied to 0.
  - Receiving a 9th data-phase bit of 0 in place of the stop bit yields `frame_err`.

## Test plan
- Parity build, reset released, `rx` idle high; send start, bits 1,0,1,0,1,0,0,1, parity 0, stop 1 at 878 time units per bit → one `done` pulse, `received_data`=0x95, `parity_err`=0, `frame_err`=0.
- Same frame with parity bit 1 → `done` pulse, `received_data`=0x95, `parity_err`=1.
- No-parity build, send 0x3C followed by stop 0 → `frame_err` pulse, no `done`, `received_data` holds its previous value.
- `rx` low for 100 cycles then high → no `done`, no `frame_err`; FSM back in IDLE and the next frame 0xA5 is received correctly.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two `done` pulses with data 0x00, then 0xFF.
- Assert `rst` during data bit 4, release it, then send 0x5A → no output for the aborted frame; `received_data`=0x5A after one `done`.
